// File: rtl/axi4_wishbone_bridge.sv
// AXI4 slave to Wishbone classic master bridge, one transaction in flight.
// Handles FIXED/INCR/WRAP bursts, byte strobes, R/W arbitration and bus timeout.
module axi4_wishbone_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,
    input  logic [ADDR_WIDTH-1:0]   axi_awaddr_i,
    input  logic [ID_WIDTH-1:0]     axi_awid_i,
    input  logic [7:0]              axi_awlen_i,
    input  logic [1:0]              axi_awburst_i,
    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,
    input  logic [DATA_WIDTH-1:0]   axi_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] axi_wstrb_i,
    input  logic                    axi_wlast_i,
    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,
    output logic [1:0]              axi_bresp_o,
    output logic [ID_WIDTH-1:0]     axi_bid_o,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,
    input  logic [ADDR_WIDTH-1:0]   axi_araddr_i,
    input  logic [ID_WIDTH-1:0]     axi_arid_i,
    input  logic [7:0]              axi_arlen_i,
    input  logic [1:0]              axi_arburst_i,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i,
    output logic [DATA_WIDTH-1:0]   axi_rdata_o,
    output logic [1:0]              axi_rresp_o,
    output logic [ID_WIDTH-1:0]     axi_rid_o,
    output logic                    axi_rlast_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_addr_o,
    output logic [DATA_WIDTH-1:0]   wb_data_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    input  logic [DATA_WIDTH-1:0]   wb_data_i,
    input  logic                    wb_ack_i
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLIM =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE, RD_BUS, RD_RESP, WR_DATA, WR_BUS, WR_RESP
    } state_t;

    state_t                state;
    logic [7:0]            len_q;
    logic [7:0]            beat_q;
    logic [1:0]            burst_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic                  err_q;
    logic                  last_wr_q;
    logic [TW-1:0]         tcnt_q;

    logic                  grant_rd;
    logic                  grant_wr;
    logic                  last_beat;
    logic                  ack_hit;
    logic                  timeout_hit;
    logic                  is_wrap;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  unused_wlast;

    assign unused_wlast = axi_wlast_i;

    // Round-robin on conflict; last_wr_q resets high so reads win first.
    assign grant_rd = axi_arvalid_i && (!axi_awvalid_i || last_wr_q);
    assign grant_wr = axi_awvalid_i && (!axi_arvalid_i || !last_wr_q);
    assign axi_arready_o = (state == IDLE) && grant_rd;
    assign axi_awready_o = (state == IDLE) && grant_wr;

    assign axi_rid_o = id_q;
    assign axi_bid_o = id_q;

    assign last_beat   = (beat_q == len_q);
    assign ack_hit     = wb_stb_o && wb_ack_i;
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && wb_stb_o && !wb_ack_i
                         && (tcnt_q == TLIM);

    // Wrap window is (len+1)*STRB_W bytes; len is 2^k-1 so it forms the mask.
    assign incr_addr = wb_addr_o + ADDR_WIDTH'(STRB_W);
    assign wrap_mask = {{(ADDR_WIDTH-8-OFF){1'b0}}, len_q, {OFF{1'b1}}};
    assign is_wrap   = (burst_q == 2'b10) &&
                       (len_q == 8'd1 || len_q == 8'd3 ||
                        len_q == 8'd7 || len_q == 8'd15);

    always_comb begin
        next_addr = incr_addr;
        if (burst_q == 2'b00) begin
            next_addr = wb_addr_o;
        end else if (is_wrap) begin
            next_addr = (wb_addr_o & ~wrap_mask) | (incr_addr & wrap_mask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            len_q        <= '0;
            beat_q       <= '0;
            burst_q      <= '0;
            id_q         <= '0;
            err_q        <= 1'b0;
            last_wr_q    <= 1'b1;
            tcnt_q       <= '0;
            axi_wready_o <= 1'b0;
            axi_bvalid_o <= 1'b0;
            axi_bresp_o  <= '0;
            axi_rvalid_o <= 1'b0;
            axi_rdata_o  <= '0;
            axi_rresp_o  <= '0;
            axi_rlast_o  <= 1'b0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_addr_o    <= '0;
            wb_data_o    <= '0;
            wb_sel_o     <= '0;
        end else begin
            tcnt_q <= wb_stb_o ? tcnt_q + TW'(1) : '0;
            unique case (state)
                IDLE: begin
                    if (axi_arready_o) begin
                        wb_addr_o <= axi_araddr_i;
                        id_q      <= axi_arid_i;
                        len_q     <= axi_arlen_i;
                        burst_q   <= axi_arburst_i;
                        beat_q    <= '0;
                        err_q     <= 1'b0;
                        last_wr_q <= 1'b0;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        wb_we_o   <= 1'b0;
                        wb_sel_o  <= '1;
                        state     <= RD_BUS;
                    end else if (axi_awready_o) begin
                        wb_addr_o    <= axi_awaddr_i;
                        id_q         <= axi_awid_i;
                        len_q        <= axi_awlen_i;
                        burst_q      <= axi_awburst_i;
                        beat_q       <= '0;
                        err_q        <= 1'b0;
                        last_wr_q    <= 1'b1;
                        axi_wready_o <= 1'b1;
                        state        <= WR_DATA;
                    end
                end
                RD_BUS: begin
                    if (ack_hit) begin
                        axi_rdata_o <= wb_data_i;
                        axi_rresp_o <= OKAY;
                    end else if (timeout_hit) begin
                        axi_rdata_o <= '0;
                        axi_rresp_o <= SLVERR;
                        err_q       <= 1'b1;
                    end
                    if (ack_hit || timeout_hit) begin
                        wb_stb_o     <= 1'b0;
                        axi_rvalid_o <= 1'b1;
                        axi_rlast_o  <= last_beat;
                        state        <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (axi_rready_i) begin
                        axi_rvalid_o <= 1'b0;
                        axi_rlast_o  <= 1'b0;
                        if (last_beat) begin
                            wb_cyc_o <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            wb_addr_o <= next_addr;
                            beat_q    <= beat_q + 8'd1;
                            wb_stb_o  <= 1'b1;
                            state     <= RD_BUS;
                        end
                    end
                end
                WR_DATA: begin
                    if (axi_wvalid_i) begin
                        if (axi_wstrb_i == '0) begin
                            if (last_beat) begin
                                axi_wready_o <= 1'b0;
                                axi_bvalid_o <= 1'b1;
                                axi_bresp_o  <= err_q ? SLVERR : OKAY;
                                state        <= WR_RESP;
                            end else begin
                                wb_addr_o <= next_addr;
                                beat_q    <= beat_q + 8'd1;
                            end
                        end else begin
                            axi_wready_o <= 1'b0;
                            wb_data_o    <= axi_wdata_i;
                            wb_sel_o     <= axi_wstrb_i;
                            wb_cyc_o     <= 1'b1;
                            wb_stb_o     <= 1'b1;
                            wb_we_o      <= 1'b1;
                            state        <= WR_BUS;
                        end
                    end
                end
                WR_BUS: begin
                    if (ack_hit || timeout_hit) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        if (timeout_hit) begin
                            err_q <= 1'b1;
                        end
                        if (last_beat) begin
                            axi_bvalid_o <= 1'b1;
                            axi_bresp_o  <= (err_q || timeout_hit) ? SLVERR : OKAY;
                            state        <= WR_RESP;
                        end else begin
                            wb_addr_o    <= next_addr;
                            beat_q       <= beat_q + 8'd1;
                            axi_wready_o <= 1'b1;
                            state        <= WR_DATA;
                        end
                    end
                end
                WR_RESP: begin
                    if (axi_bready_i) begin
                        axi_bvalid_o <= 1'b0;
                        axi_bresp_o  <= '0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_wishbone_bridge.sv
// Scoreboard bench for axi4_wishbone_bridge with a delay-scripted Wishbone slave.
// Expected WB/R/B transactions are queued by stimulus and popped by the monitor.
module tb_axi4_wishbone_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        axi_awvalid_i = 1'b0;
    logic        axi_awready_o;
    logic [31:0] axi_awaddr_i = '0;
    logic [3:0]  axi_awid_i = '0;
    logic [7:0]  axi_awlen_i = '0;
    logic [1:0]  axi_awburst_i = '0;
    logic        axi_wvalid_i = 1'b0;
    logic        axi_wready_o;
    logic [31:0] axi_wdata_i = '0;
    logic [3:0]  axi_wstrb_i = '0;
    logic        axi_wlast_i = 1'b0;
    logic        axi_bvalid_o;
    logic        axi_bready_i = 1'b0;
    logic [1:0]  axi_bresp_o;
    logic [3:0]  axi_bid_o;
    logic        axi_arvalid_i = 1'b0;
    logic        axi_arready_o;
    logic [31:0] axi_araddr_i = '0;
    logic [3:0]  axi_arid_i = '0;
    logic [7:0]  axi_arlen_i = '0;
    logic [1:0]  axi_arburst_i = '0;
    logic        axi_rvalid_o;
    logic        axi_rready_i = 1'b0;
    logic [31:0] axi_rdata_o;
    logic [1:0]  axi_rresp_o;
    logic [3:0]  axi_rid_o;
    logic        axi_rlast_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_data_i = '0;
    logic        wb_ack_i = 1'b0;

    always #5 clk = ~clk;

    axi4_wishbone_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
        .axi_awaddr_i(axi_awaddr_i), .axi_awid_i(axi_awid_i),
        .axi_awlen_i(axi_awlen_i), .axi_awburst_i(axi_awburst_i),
        .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
        .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i),
        .axi_wlast_i(axi_wlast_i),
        .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready_i),
        .axi_bresp_o(axi_bresp_o), .axi_bid_o(axi_bid_o),
        .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
        .axi_araddr_i(axi_araddr_i), .axi_arid_i(axi_arid_i),
        .axi_arlen_i(axi_arlen_i), .axi_arburst_i(axi_arburst_i),
        .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i),
        .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
        .axi_rid_o(axi_rid_o), .axi_rlast_o(axi_rlast_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_sel_o(wb_sel_o),
        .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
    } wb_exp_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } r_exp_t;

    typedef struct packed {
        logic [1:0] resp;
        logic [3:0] id;
    } b_exp_t;

    wb_exp_t     wb_q[$];
    r_exp_t      r_q[$];
    b_exp_t      b_q[$];
    int          ack_dly_q[$];
    logic [31:0] rd_data_q[$];
    int          grant_log[$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_wb(input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        wb_exp_t e;
        e.we = we; e.addr = a; e.data = d; e.sel = s;
        wb_q.push_back(e);
    endtask

    task automatic push_r(input logic [31:0] d, input logic [1:0] resp,
                          input logic last, input logic [3:0] id);
        r_exp_t e;
        e.data = d; e.resp = resp; e.last = last; e.id = id;
        r_q.push_back(e);
    endtask

    task automatic push_b(input logic [1:0] resp, input logic [3:0] id);
        b_exp_t e;
        e.resp = resp; e.id = id;
        b_q.push_back(e);
    endtask

    // Wishbone slave: acks after a scripted number of stb cycles per beat.
    int   cur_dly = 1;
    int   dly_cnt = 0;
    logic active = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            wb_ack_i = 1'b0;
            active = 1'b0;
        end else if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
            if (!active) begin
                active = 1'b1;
                dly_cnt = 0;
                cur_dly = 1;
                if (ack_dly_q.size() > 0) cur_dly = ack_dly_q.pop_front();
            end
            if (dly_cnt == cur_dly) begin
                wb_ack_i = 1'b1;
                wb_data_i = 32'h0;
                if (!wb_we_o && rd_data_q.size() > 0)
                    wb_data_i = rd_data_q.pop_front();
            end else begin
                dly_cnt++;
            end
        end else begin
            wb_ack_i = 1'b0;
            active = 1'b0;
        end
    end

    int r_idx = 0;
    int stall_beat = -1;
    int stall_left = 0;
    always @(posedge clk) begin
        #1;
        if (stall_left > 0 && axi_rvalid_o && r_idx == stall_beat) begin
            axi_rready_i = 1'b0;
            stall_left--;
        end else begin
            axi_rready_i = 1'b1;
        end
    end

    logic        prev_stall = 1'b0;
    logic [31:0] prev_rdata = '0;
    logic        rd_ack_seen = 1'b0;
    always @(negedge clk) begin : monitor
        wb_exp_t ew;
        r_exp_t  er;
        b_exp_t  eb;
        if (rst_n) begin
            if (rd_ack_seen) check("rvalid_after_ack", 64'(axi_rvalid_o), 1);
            rd_ack_seen = wb_cyc_o && wb_stb_o && wb_ack_i && !wb_we_o;
            if (prev_stall) begin
                check("stall_rdata", 64'(axi_rdata_o), 64'(prev_rdata));
                check("stall_cyc", 64'(wb_cyc_o), 1);
            end
            prev_stall = axi_rvalid_o && !axi_rready_i;
            prev_rdata = axi_rdata_o;
            if (axi_arvalid_i && axi_arready_o) grant_log.push_back(0);
            if (axi_awvalid_i && axi_awready_o) grant_log.push_back(1);
            if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
                if (wb_q.size() == 0) begin
                    check("wb_unexpected", 1, 0);
                end else begin
                    ew = wb_q.pop_front();
                    check("wb_we", 64'(wb_we_o), 64'(ew.we));
                    check("wb_addr", 64'(wb_addr_o), 64'(ew.addr));
                    check("wb_sel", 64'(wb_sel_o), 64'(ew.sel));
                    if (ew.we) check("wb_wdata", 64'(wb_data_o), 64'(ew.data));
                end
            end
            if (axi_rvalid_o && axi_rready_i) begin
                if (r_q.size() == 0) begin
                    check("r_unexpected", 1, 0);
                end else begin
                    er = r_q.pop_front();
                    check("rdata", 64'(axi_rdata_o), 64'(er.data));
                    check("rresp", 64'(axi_rresp_o), 64'(er.resp));
                    check("rlast", 64'(axi_rlast_o), 64'(er.last));
                    check("rid", 64'(axi_rid_o), 64'(er.id));
                end
                r_idx = axi_rlast_o ? 0 : r_idx + 1;
            end
            if (axi_bvalid_o && axi_bready_i) begin
                if (b_q.size() == 0) begin
                    check("b_unexpected", 1, 0);
                end else begin
                    eb = b_q.pop_front();
                    check("bresp", 64'(axi_bresp_o), 64'(eb.resp));
                    check("bid", 64'(axi_bid_o), 64'(eb.id));
                end
            end
        end
    end

    // Drivers are entered just after a rising edge and return likewise.
    task automatic ar_send(input logic [31:0] a, input logic [3:0] id,
                           input logic [7:0] len, input logic [1:0] burst);
        bit ok = 0;
        axi_arvalid_i = 1'b1; axi_araddr_i = a; axi_arid_i = id;
        axi_arlen_i = len; axi_arburst_i = burst;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (axi_arready_o) begin ok = 1; break; end
        end
        if (!ok) check("ar_handshake_timeout", 0, 1);
        @(posedge clk); #1;
        axi_arvalid_i = 1'b0;
    endtask

    task automatic aw_send(input logic [31:0] a, input logic [3:0] id,
                           input logic [7:0] len, input logic [1:0] burst);
        bit ok = 0;
        axi_awvalid_i = 1'b1; axi_awaddr_i = a; axi_awid_i = id;
        axi_awlen_i = len; axi_awburst_i = burst;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (axi_awready_o) begin ok = 1; break; end
        end
        if (!ok) check("aw_handshake_timeout", 0, 1);
        @(posedge clk); #1;
        axi_awvalid_i = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s,
                          input logic last);
        bit ok = 0;
        axi_wvalid_i = 1'b1; axi_wdata_i = d;
        axi_wstrb_i = s; axi_wlast_i = last;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (axi_wready_o) begin ok = 1; break; end
        end
        if (!ok) check("w_handshake_timeout", 0, 1);
        @(posedge clk); #1;
        axi_wvalid_i = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (wb_q.size() == 0 && r_q.size() == 0 && b_q.size() == 0 &&
                !axi_rvalid_o && !axi_bvalid_o && !wb_cyc_o) begin
                ok = 1; break;
            end
        end
        if (!ok) check("drain_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        #1;
        check("rst_wb_ctrl", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 0);
        check("rst_wb_addr", 64'(wb_addr_o), 0);
        check("rst_wb_data_sel", 64'({wb_data_o, wb_sel_o}), 0);
        check("rst_axi_ready", 64'({axi_awready_o, axi_wready_o, axi_arready_o}), 0);
        check("rst_axi_r", 64'({axi_rvalid_o, axi_rdata_o, axi_rresp_o,
                                axi_rid_o, axi_rlast_o}), 0);
        check("rst_axi_b", 64'({axi_bvalid_o, axi_bresp_o, axi_bid_o}), 0);
        axi_bready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single read, ack 2 cycles after stb.
        ack_dly_q.push_back(2);
        rd_data_q.push_back(32'hDEADBEEF);
        push_wb(1'b0, 32'h100, 32'h0, 4'hF);
        push_r(32'hDEADBEEF, 2'b00, 1'b1, 4'h3);
        ar_send(32'h100, 4'h3, 8'd0, 2'b01);
        check("stb_after_ar", 64'(wb_stb_o), 1);
        check("addr_after_ar", 64'(wb_addr_o), 64'h100);
        wait_done();

        // WRAP burst with a 3-cycle rready stall on the second beat.
        for (int i = 0; i < 4; i++) begin
            ack_dly_q.push_back(1);
            rd_data_q.push_back(32'hA0A0_0001 + 32'(i));
            push_r(32'hA0A0_0001 + 32'(i), 2'b00, i == 3, 4'h5);
        end
        push_wb(1'b0, 32'h38, 32'h0, 4'hF);
        push_wb(1'b0, 32'h3C, 32'h0, 4'hF);
        push_wb(1'b0, 32'h30, 32'h0, 4'hF);
        push_wb(1'b0, 32'h34, 32'h0, 4'hF);
        stall_beat = 1;
        stall_left = 3;
        ar_send(32'h38, 4'h5, 8'd3, 2'b10);
        wait_done();
        check("stall_consumed", 64'(stall_left), 0);
        stall_beat = -1;

        // INCR write burst with a zero-strobe middle beat.
        ack_dly_q.push_back(1);
        ack_dly_q.push_back(1);
        push_wb(1'b1, 32'h200, 32'h1111_0000, 4'hF);
        push_wb(1'b1, 32'h208, 32'h3333_0002, 4'h3);
        push_b(2'b00, 4'h9);
        aw_send(32'h200, 4'h9, 8'd2, 2'b01);
        w_beat(32'h1111_0000, 4'hF, 1'b0);
        w_beat(32'h2222_0001, 4'h0, 1'b0);
        w_beat(32'h3333_0002, 4'h3, 1'b1);
        wait_done();

        // Arbitration: read first from reset, then write beats a second read.
        grant_log.delete();
        repeat (3) ack_dly_q.push_back(1);
        rd_data_q.push_back(32'h1111_1111);
        rd_data_q.push_back(32'h2222_2222);
        push_wb(1'b0, 32'h300, 32'h0, 4'hF);
        push_wb(1'b1, 32'h340, 32'hAAAA_5555, 4'hF);
        push_wb(1'b0, 32'h380, 32'h0, 4'hF);
        push_r(32'h1111_1111, 2'b00, 1'b1, 4'h1);
        push_r(32'h2222_2222, 2'b00, 1'b1, 4'h4);
        push_b(2'b00, 4'h2);
        fork
            begin
                ar_send(32'h300, 4'h1, 8'd0, 2'b01);
                ar_send(32'h380, 4'h4, 8'd0, 2'b01);
            end
            begin
                aw_send(32'h340, 4'h2, 8'd0, 2'b01);
                w_beat(32'hAAAA_5555, 4'hF, 1'b1);
            end
        join
        wait_done();
        check("grant_count", 64'(grant_log.size()), 3);
        if (grant_log.size() == 3) begin
            check("grant_0_read", 64'(grant_log[0]), 0);
            check("grant_1_write", 64'(grant_log[1]), 1);
            check("grant_2_read", 64'(grant_log[2]), 0);
        end

        // Timeout on beat 0, success on beat 1.
        ack_dly_q.push_back(10);
        ack_dly_q.push_back(1);
        rd_data_q.push_back(32'h1234_5678);
        push_wb(1'b0, 32'h404, 32'h0, 4'hF);
        push_r(32'h0, 2'b10, 1'b0, 4'h6);
        push_r(32'h1234_5678, 2'b00, 1'b1, 4'h6);
        ar_send(32'h400, 4'h6, 8'd1, 2'b01);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wb_stb_o) n++;
            else break;
        end
        check("timeout_stb_cycles", 64'(n), 4);
        wait_done();

        // Asynchronous reset while the write is on the bus.
        ack_dly_q.push_back(10);
        aw_send(32'h500, 4'h7, 8'd0, 2'b01);
        w_beat(32'h5555_5555, 4'hF, 1'b1);
        check("wr_bus_stb", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'b111);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_wb", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 0);
        check("async_rst_bvalid", 64'(axi_bvalid_o), 0);
        ack_dly_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_bvalid_after_rst", 64'(axi_bvalid_o), 0);
        end
        @(posedge clk); #1;
        ack_dly_q.push_back(1);
        push_wb(1'b1, 32'h600, 32'hCAFE_F00D, 4'hC);
        push_b(2'b00, 4'h8);
        aw_send(32'h600, 4'h8, 8'd0, 2'b01);
        w_beat(32'hCAFE_F00D, 4'hC, 1'b1);
        wait_done();

        check("queues_empty", 64'(wb_q.size() + r_q.size() + b_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi4_wishbone_bridge.md
Name: axi4_wishbone_bridge

Overview:
- Parametrised AXI4 slave to Wishbone classic master bridge.
- Connects one AXI4 master port of a core (instruction or data side) to the Controller's core_* / data_mem_* Wishbone bus in processorci_top.
- Supports INCR, FIXED and WRAP bursts, byte strobes, read/write arbitration, and an optional bus timeout that returns SLVERR.
- Instantiate once per AXI port.

Parameters:
- ADDR_WIDTH, 32, AXI and Wishbone address width.
- DATA_WIDTH, 32, data width; 32 or 64 only; STRB_W = DATA_WIDTH/8.
- ID_WIDTH, 4, AXI ID width; the ID is echoed on the response.
- TIMEOUT_CYCLES, 0, maximum cycles to wait for wb_ack_i per beat; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- axi_awvalid_i / axi_awready_o  in/out  1  write address handshake
- axi_awaddr_i  in  ADDR_WIDTH  write start address
- axi_awid_i  in  ID_WIDTH  write ID
- axi_awlen_i  in  8  beats-1
- axi_awburst_i  in  2  00 FIXED, 01 INCR, 10 WRAP
- axi_wvalid_i / axi_wready_o  in/out  1  write data handshake
- axi_wdata_i  in  DATA_WIDTH  write data
- axi_wstrb_i  in  STRB_W  byte strobes
- axi_wlast_i  in  1  last beat (ignored)
- axi_bvalid_o / axi_bready_i  out/in  1  write response handshake
- axi_bresp_o  out  2  write response
- axi_bid_o  out  ID_WIDTH  write response ID
- axi_arvalid_i / axi_arready_o  in/out  1  read address handshake
- axi_araddr_i  in  ADDR_WIDTH  read start address
- axi_arid_i  in  ID_WIDTH  read ID
- axi_arlen_i  in  8  beats-1
- axi_arburst_i  in  2  burst type
- axi_rvalid_o / axi_rready_i  out/in  1  read data handshake
- axi_rdata_o  out  DATA_WIDTH  read data
- axi_rresp_o  out  2  read response
- axi_rid_o  out  ID_WIDTH  read ID
- axi_rlast_o  out  1  last read beat
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone control
- wb_addr_o  out  ADDR_WIDTH  Wishbone address
- wb_data_o  out  DATA_WIDTH  Wishbone write data
- wb_sel_o  out  STRB_W  Wishbone byte select
- wb_data_i  in  DATA_WIDTH  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; beat counter 0; timeout counter 0; error flag 0; last_grant=WRITE.
  - Reset is asynchronous: when asserted mid-burst, cyc/stb drop immediately and the burst is discarded with no response.
- Only one transaction is in flight at a time.
- States: IDLE, RD_BUS, RD_RESP, WR_DATA, WR_BUS, WR_RESP.
- IDLE:
  - axi_arready_o = read granted; axi_awready_o = write granted (combinational).
  - If only one request is valid, it is granted.
  - If both are valid, the type opposite to last_grant is granted, so the read wins first after reset.
  - On handshake, latch addr, id, len, burst; clear error flag and beat counter.
- Read path:
  - RD_BUS: cyc=stb=1, we=0, sel all ones.
  - On wb_ack_i, register wb_data_i into rdata with rresp=00, stb=0, go to RD_RESP.
  - RD_RESP: rvalid=1; rlast=1 when beat==len.
  - On rvalid&rready: if last, cyc=0 and go to IDLE; otherwise advance the address, beat++, go to RD_BUS.
  - cyc stays high for the whole burst.
  - Latency: AR handshake at edge N gives stb high in cycle N+1; ack at edge M gives rvalid in cycle M+1.
- Write path:
  - WR_DATA: wready=1. On handshake, latch wdata/wstrb.
  - wstrb==0: no Wishbone cycle; beat counts as done.
  - Otherwise go to WR_BUS: cyc=stb=we=1, sel=wstrb, wb_data_o=wdata. Wait for ack.
  - Beat count is governed by awlen only; wlast is ignored.
  - After the final beat, go to WR_RESP: bvalid=1; bresp=10 if the error flag is set, else 00; bid = latched ID.
  - On bready, go to IDLE.
- Address update per beat, with B = STRB_W:
  - FIXED: unchanged.
  - INCR: +B.
  - WRAP: +B, wrapping within a (len+1)*B aligned window; len not in {1,3,7,15} is treated as INCR.
  - burst 11 is treated as INCR.
  - Arithmetic is modulo 2^ADDR_WIDTH.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter runs while stb=1 and resets per beat.
  - On reaching TIMEOUT_CYCLES without an ack: stb=0, set the error flag, and continue the burst.
  - A timed-out read beat returns rdata=0, rresp=10.
  - An ack arriving in the same cycle as expiry takes precedence as success.
- wb_ack_i while stb=0 is ignored.

Test Plan:
- Single read, addr 0x100, len 0, INCR; ack 2 cycles after stb with data 0xDEADBEEF -> one WB read at 0x100; rvalid in the cycle after ack; rdata=0xDEADBEEF, rresp=00, rlast=1, rid echoed.
- Read burst at 0x38, len 3, WRAP, DATA_WIDTH=32 -> WB addresses 0x38, 0x3C, 0x30, 0x34; rlast only on the 4th beat; rready held low for 3 cycles on beat 2 keeps rdata stable and cyc high.
- Write burst at 0x200, len 2, INCR, wstrb 0xF, 0x0, 0x3 -> WB writes at 0x200 (sel F) and 0x208 (sel 3); no cycle for 0x204; bresp=00 with bid echoed.
- arvalid and awvalid both high in IDLE from reset -> read granted first, write next; repeat both -> write granted first.
- TIMEOUT_CYCLES=4, read len 1, no ack on beat 0 -> stb drops after 4 cycles; beat 0 has rdata=0, rresp=10; beat 1 (acked) has rresp=00.
- rst_n low during WR_BUS -> cyc/stb/we go 0 asynchronously; no bvalid; next AW is accepted normally after release.
